// File: rtl/lol_pkg.sv
// Shared types and defaults for the LOL word detector.
package lol_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GOT_L  = 2'd1,
        GOT_LO = 2'd2
    } state_e;

    typedef struct packed {
        logic l;
        logic o;
        logic y;
    } letters_t;

    localparam int GAP_MAX_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    function automatic logic multi_ev(input letters_t e);
        return (e.l & e.o) | (e.l & e.y) | (e.o & e.y);
    endfunction

endpackage

// File: rtl/lol_edge_detect.sv
// Registers the letter levels once and flags their 0->1 transitions.
module lol_edge_detect
    import lol_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n_i,
    input  letters_t lvl_i,
    output letters_t ev_o
);

    letters_t cur_q;
    letters_t prev_q;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cur_q  <= '0;
            prev_q <= '0;
        end else begin
            cur_q  <= lvl_i;
            prev_q <= cur_q;
        end
    end

    // Cleared history makes a level held across reset look like a new edge.
    assign ev_o = letters_t'(cur_q & ~prev_q);

endmodule

// File: rtl/lol_word_detector.sv
// Detects "LOL" in a stream of letter events, with gap timeout
// and a saturating word counter.
module lol_word_detector
    import lol_pkg::*;
#(
    parameter int GAP_MAX = GAP_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             restart,
    input  logic             L,
    input  logic             O,
    input  logic             Y,
    output logic             lol,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             err
);

    localparam int GAP_W = $clog2(GAP_MAX + 1);

    letters_t         lvl;
    letters_t         ev;
    logic             any_ev;
    logic             coll;
    logic             timeout;
    state_e           state_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             lol_q;
    logic             err_q;

    assign lvl = '{l: L, o: O, y: Y};

    lol_edge_detect u_edge (
        .clk     (clk),
        .rst_n_i (restart),
        .lvl_i   (lvl),
        .ev_o    (ev)
    );

    assign any_ev  = ev.l | ev.o | ev.y;
    assign coll    = multi_ev(ev);
    assign timeout = (state_q != IDLE) && !any_ev
                     && (gap_q == GAP_W'(GAP_MAX - 1));

    assign gap_d   = (state_q == IDLE || any_ev || timeout)
                     ? '0 : gap_q + 1'b1;
    assign count_d = (count_q == '1) ? count_q : count_q + 1'b1;

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state_q <= IDLE;
            gap_q   <= '0;
            count_q <= '0;
            lol_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            lol_q <= 1'b0;
            err_q <= 1'b0;
            gap_q <= gap_d;
            if (coll) begin
                state_q <= IDLE;
                err_q   <= (state_q != IDLE);
            end else if (timeout) begin
                state_q <= IDLE;
                err_q   <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (ev.l) state_q <= GOT_L;
                    end
                    GOT_L: begin
                        if (ev.o) begin
                            state_q <= GOT_LO;
                        end else if (ev.y) begin
                            state_q <= IDLE;
                            err_q   <= 1'b1;
                        end
                    end
                    GOT_LO: begin
                        // The closing L also opens the next word.
                        if (ev.l) begin
                            state_q <= GOT_L;
                            lol_q   <= 1'b1;
                            count_q <= count_d;
                        end else if (ev.o || ev.y) begin
                            state_q <= IDLE;
                            err_q   <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign lol   = lol_q;
    assign err   = err_q;
    assign count = count_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: doc/lol_word_detector.md
LOL_WORD_DETECTOR -- requirements
Module: lol_word_detector

Interface
REQ-001 Parameter GAP_MAX, default 8: max letter-free cycles tolerated inside a partial match.
REQ-002 Parameter CNT_W, default 8: width of the word counter.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state on rising edge.
REQ-004 The block SHALL have port restart, input, 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port L, input, 1: letter-L level from upstream letter reader.
REQ-006 The block SHALL have port O, input, 1: letter-O level from upstream letter reader.
REQ-007 The block SHALL have port Y, input, 1: letter-Y level from upstream letter reader.
REQ-008 The block SHALL have port lol, output, 1: one-cycle pulse per completed "LOL".
REQ-009 The block SHALL have port count, output, CNT_W: saturating total of detected words.
REQ-010 The block SHALL have port busy, output, 1: high while a partial match (L or LO) is held.
REQ-011 The block SHALL have port err, output, 1: one-cycle pulse when a partial match is abandoned.

Function
REQ-012 Inputs SHALL be registered once; a letter event SHALL be a 0->1 transition of that registered input; a held level SHALL produce no further events.
REQ-013 More than one event in the same cycle SHALL be a collision.
REQ-014 The FSM SHALL have states IDLE, GOT_L and GOT_LO; busy SHALL be 1 exactly in GOT_L and GOT_LO.
REQ-015 IDLE: L event -> GOT_L; O or Y event -> IDLE, no err.
REQ-016 GOT_L: L event -> GOT_L; O event -> GOT_LO; Y event -> IDLE with err.
REQ-017 GOT_LO: L event -> GOT_L with lol pulse (trailing L reused, so "LOLOL" yields 2 words); O or Y event -> IDLE with err.
REQ-018 Collision: any state -> IDLE; err SHALL pulse only if the prior state was busy.
REQ-019 Gap counter: cleared on any event or in IDLE; increments each busy cycle without an event.
REQ-020 When the gap counter reaches GAP_MAX, the FSM SHALL go to IDLE with err.
REQ-021 An event after GAP_MAX-1 empty cycles SHALL be accepted; after GAP_MAX empty cycles it SHALL be rejected.
REQ-022 lol and err SHALL be registered, asserted in the cycle after the edge that takes the transition.
REQ-023 count SHALL increment on the same edge lol rises.
REQ-024 count SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-025 Latency from upstream letter level to lol SHALL be 2 clock edges (input register plus FSM).

Reset
REQ-026 restart=0 SHALL asynchronously force IDLE, gap=0, input registers=0, lol=0, err=0, busy=0 and count=0.
REQ-027 Reset mid-match SHALL discard the partial match with no err pulse.
REQ-028 Letter levels held high across reset release SHALL count as events on the first edge after release.

Structure
REQ-029 The state encoding and default GAP_MAX/CNT_W constants SHALL reside in a shared package lol_pkg.
REQ-030 The event extraction (input register plus rising-edge detect) SHALL be one sub-module, lol_edge_detect; the FSM, gap counter and word counter SHALL live in the top module.
REQ-031 Target size SHALL be 150-250 lines of RTL.

Verification
REQ-032 Events L,O,L one cycle apart -> lol=1 for one cycle; count=1; busy falls never (ends in GOT_L).
REQ-033 Events L,O,L,O,L -> two lol pulses, count=2.
REQ-034 Event L, then L held high 5 cycles, then O, L -> one word only; the held level generates no extra events.
REQ-035 Events L,Y -> err pulse, busy=0, count unchanged. Separately, L then O with 8 empty cycles between them -> err at timeout and O ignored; with 7 empty cycles -> O accepted.
REQ-036 L and O rising together in GOT_L -> err, IDLE. Separately, restart=0 in GOT_LO -> immediate IDLE, count=0, no err.
REQ-037 CNT_W=2 with 5 words -> count stops at 3, lol still pulses 5 times.
